mic_level_meter: RTL and testbench

Downstream consumer of the 12-bit microphone sample stream from `Audio_Input`. It rectifies each sample about mid-scale and tracks the peak amplitude over a fixed window of samples. At every window boundary it publishes a 0–9 volume level with a one-cycle strobe. The level drives the 9-LED bar, the seven-segment volume digit and the OLED/audio tasks that react to loudness.

---
 rtl/mic_meter_pkg.sv | 24 ++
 rtl/amp_to_level.sv | 22 ++
 rtl/mic_level_meter.sv | 136 +++++++++++++
 tb/tb_mic_level_meter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mic_meter_pkg.sv
// Shared constants, types and the level-to-thermometer encoder for the
// microphone volume meter and the displays that show its level.
package mic_meter_pkg;

  localparam int MIC_MID    = 2048;
  localparam int LEVEL_W    = 4;
  localparam int NUM_LEVELS = 10;
  localparam int AMP_W      = 11;

  typedef logic [LEVEL_W-1:0]    level_t;
  typedef logic [AMP_W-1:0]      amp_t;
  typedef logic [NUM_LEVELS-2:0] bar_t;

  // Bit i of the bar is lit when the level exceeds i.
  function automatic bar_t thermo_encode(input level_t lvl);
    bar_t bar;
    bar = '0;
    for (int i = 0; i < NUM_LEVELS - 1; i++) begin
      bar[i] = (lvl > LEVEL_W'(i));
    end
    return bar;
  endfunction

endpackage

// File: rtl/amp_to_level.sv
// Maps an 11-bit rectified amplitude onto a 0..9 volume level: the level is
// the number of thresholds k*THRESH_STEP (k = 1..9) the amplitude reaches.
module amp_to_level
  import mic_meter_pkg::*;
#(
  parameter int THRESH_STEP = 205
) (
  input  logic [10:0] amp,
  output logic [3:0]  level
);

  // NOTE: combinational outputs get a default first so no path can infer a latch.
  always_comb begin
    level = '0;
    for (int k = 1; k < NUM_LEVELS; k++) begin
      if (int'(amp) >= k * THRESH_STEP) begin
        level = level + LEVEL_W'(1);
      end
    end
  end

endmodule

// File: rtl/mic_level_meter.sv
// Windowed peak meter for the 12-bit mic stream; publishes a 0..9 level per
// window. Optional peak-hold decay is built when MIC_PEAK_HOLD_EN is defined.
module mic_level_meter
  import mic_meter_pkg::*;
#(
  parameter int WINDOW       = 4000,
  parameter int THRESH_STEP  = 205,
  parameter int HOLD_WINDOWS = 5
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        sample_valid,
  input  logic [11:0] sample,
  output logic [3:0]  level,
  output logic [8:0]  led_bar,
  output logic        level_valid
);

  localparam int CNT_W = 16;

  // Parameter legality is checked at elaboration so a bad build never synthesizes.
  if (WINDOW < 2 || WINDOW > 65535) begin : g_bad_window
    $error("mic_level_meter: WINDOW must be in 2..65535");
  end
  if (9 * THRESH_STEP > 2047 || THRESH_STEP < 1) begin : g_bad_step
    $error("mic_level_meter: 9*THRESH_STEP must be 1..2047");
  end
  if (HOLD_WINDOWS < 1) begin : g_bad_hold
    $error("mic_level_meter: HOLD_WINDOWS must be at least 1");
  end

  amp_t             amp;
  amp_t             amp_r;
  amp_t             peak;
  amp_t             pk;
  logic             last_r;
  logic             s1_valid;
  logic [CNT_W-1:0] sample_cnt;
  level_t           new_level;
  level_t           pub_level;

  // Fold about mid-scale: 2048 -> 0, both 0 and 4095 -> 2047.
  always_comb begin
    if (sample >= 12'(MIC_MID)) amp = AMP_W'(sample - 12'(MIC_MID));
    else                        amp = AMP_W'(12'(MIC_MID - 1) - sample);
  end

  // NOTE: clocked state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      amp_r      <= '0;
      last_r     <= 1'b0;
      sample_cnt <= '0;
    end else begin
      s1_valid <= sample_valid;
      if (sample_valid) begin
        amp_r  <= amp;
        last_r <= (sample_cnt == CNT_W'(WINDOW - 1));
        if (sample_cnt == CNT_W'(WINDOW - 1)) sample_cnt <= '0;
        else                                  sample_cnt <= sample_cnt + CNT_W'(1);
      end
    end
  end

  assign pk = (amp_r > peak) ? amp_r : peak;

  amp_to_level #(
    .THRESH_STEP(THRESH_STEP)
  ) u_amp_to_level (
    .amp  (pk),
    .level(new_level)
  );

`ifdef MIC_PEAK_HOLD_EN
  localparam int HC_W = $clog2(HOLD_WINDOWS) + 1;

  level_t          held;
  level_t          next_held;
  logic [HC_W-1:0] hold_cnt;
  logic [HC_W-1:0] next_hold_cnt;

  // A louder window takes over at once; a quieter one decays by one step per hold period.
  always_comb begin
    next_held     = held;
    next_hold_cnt = hold_cnt;
    if (new_level >= held) begin
      next_held     = new_level;
      next_hold_cnt = '0;
    end else if (hold_cnt == HC_W'(HOLD_WINDOWS - 1)) begin
      next_held     = ((held - LEVEL_W'(1)) > new_level) ? held - LEVEL_W'(1) : new_level;
      next_hold_cnt = '0;
    end else begin
      next_hold_cnt = hold_cnt + HC_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      held     <= '0;
      hold_cnt <= '0;
    end else if (s1_valid && last_r) begin
      held     <= next_held;
      hold_cnt <= next_hold_cnt;
    end
  end

  assign pub_level = next_held;
`else
  assign pub_level = new_level;
`endif

  // The window's last sample is folded into pk before the peak clears, so the
  // following window always starts from zero.
  always_ff @(posedge clock) begin
    if (rst) begin
      peak        <= '0;
      level       <= '0;
      led_bar     <= '0;
      level_valid <= 1'b0;
    end else begin
      level_valid <= 1'b0;
      if (s1_valid) begin
        if (last_r) begin
          peak        <= '0;
          level       <= pub_level;
          led_bar     <= thermo_encode(pub_level);
          level_valid <= 1'b1;
        end else begin
          peak <= pk;
        end
      end
    end
  end

endmodule

// File: tb/tb_mic_level_meter.sv
// Scoreboard bench for mic_level_meter: directed cases from the test plan plus
// randomized windows, gaps and resets checked against an arithmetic model.
module tb_mic_level_meter;

  localparam int WINDOW       = 4;
  localparam int THRESH_STEP  = 205;
  localparam int HOLD_WINDOWS = 2;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        sample_valid = 1'b0;
  logic [11:0] sample = '0;
  logic [3:0]  level;
  logic [8:0]  led_bar;
  logic        level_valid;

  mic_level_meter #(
    .WINDOW      (WINDOW),
    .THRESH_STEP (THRESH_STEP),
    .HOLD_WINDOWS(HOLD_WINDOWS)
  ) dut (
    .clock       (clock),
    .rst         (rst),
    .sample_valid(sample_valid),
    .sample      (sample),
    .level       (level),
    .led_bar     (led_bar),
    .level_valid (level_valid)
  );

  always #5 clock = ~clock;

  int   cyc = 0;
  logic rst_q = 1'b0;
  logic mon_en = 1'b0;
  always @(posedge clock) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int lvl;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   win_peak = 0;
  int   win_n = 0;
  int   m_held = 0;
  int   m_hc = 0;

  function automatic int rect(input int s);
    return (s >= 2048) ? s - 2048 : 2047 - s;
  endfunction

  function automatic int to_level(input int a);
    int n = 0;
    for (int k = 1; k <= 9; k++) if (a >= k * THRESH_STEP) n++;
    return n;
  endfunction

  function automatic int thermo(input int l);
    int b = 0;
    for (int i = 0; i < 9; i++) if (l > i) b = b | (1 << i);
    return b;
  endfunction

  function automatic int window_done(input int nl);
`ifdef MIC_PEAK_HOLD_EN
    if (nl >= m_held) begin
      m_held = nl;
      m_hc   = 0;
    end else if (m_hc == HOLD_WINDOWS - 1) begin
      m_held = (m_held - 1 > nl) ? m_held - 1 : nl;
      m_hc   = 0;
    end else begin
      m_hc++;
    end
    return m_held;
`else
    return nl;
`endif
  endfunction

  // ---------------- stimulus ----------------
  task automatic drive(input int s);
    exp_t e;
    @(posedge clock);
    #2;
    sample_valid = 1'b1;
    sample       = 12'(s);
    if (rect(s) > win_peak) win_peak = rect(s);
    win_n++;
    if (win_n == WINDOW) begin
      e.lvl = window_done(to_level(win_peak));
      e.cyc = cyc + 2;
      exp_q.push_back(e);
      win_n    = 0;
      win_peak = 0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #2;
      sample_valid = 1'b0;
    end
  endtask

  // One-cycle reset; a sample offered alongside it must be ignored, and any
  // pulse that would land on or after the reset edge is discarded.
  task automatic do_reset();
    @(posedge clock);
    #2;
    rst          = 1'b1;
    sample_valid = 1'($urandom_range(0, 1));
    sample       = 12'($urandom_range(0, 4095));
    while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc > cyc) void'(exp_q.pop_back());
    win_n    = 0;
    win_peak = 0;
    m_held   = 0;
    m_hc     = 0;
    @(posedge clock);
    #2;
    rst          = 1'b0;
    sample_valid = 1'b0;
  endtask

  task automatic window4(input int a, input int b, input int c, input int d);
    drive(a);
    drive(b);
    drive(c);
    drive(d);
  endtask

  // ---------------- monitor ----------------
  int last_lvl = 0;
  always @(negedge clock) begin
    exp_t e;
    if (mon_en) begin
      if (rst_q) begin
        check("reset level", int'(level), 0);
        check("reset led_bar", int'(led_bar), 0);
        check("reset level_valid", int'(level_valid), 0);
        last_lvl = 0;
      end else if (level_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected pulse: level %0d at cycle %0d, none expected", level, cyc);
        end else begin
          e = exp_q.pop_front();
          check("pulse level", int'(level), e.lvl);
          check("pulse led_bar", int'(led_bar), thermo(e.lvl));
          check("pulse cycle", cyc, e.cyc);
          last_lvl = e.lvl;
        end
      end else begin
        check("held level", int'(level), last_lvl);
        check("held led_bar", int'(led_bar), thermo(last_lvl));
      end
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    int s;
    repeat (3) @(posedge clock);
    #2;
    rst    = 1'b0;
    mon_en = 1'b1;

    // Silence, then full scale.
    window4(2048, 2048, 2048, 2048);
    idle(3);
    window4(2048, 4095, 2048, 2048);
    idle(3);

    // Threshold edges.
    do_reset();
    window4(2048, 2048 + 409, 2048, 2048);
    idle(3);
    window4(2048, 2048, 2048 + 410, 2048);
    idle(3);
    window4(0, 2048, 2048, 2048);
    idle(3);

    // Peak as the last sample, next window back-to-back.
    do_reset();
    window4(2048, 2100, 2048, 3000);
    window4(2048, 2048, 2048, 2048);
    idle(3);

    // Mid-window reset discards the partial window.
    do_reset();
    drive(4095);
    drive(4095);
    drive(4095);
    do_reset();
    window4(2048, 2048, 2048, 2048);
    idle(3);

    // Reset right behind a completed window kills the in-flight pulse.
    window4(4095, 4095, 4095, 4095);
    do_reset();
    idle(3);

    // Hold/decay behaviour: a loud window followed by silence.
    do_reset();
    window4(0, 2048, 2048, 2048);
    repeat (6) window4(2048, 2048, 2048, 2048);
    idle(3);

    // Randomized traffic with gaps, threshold-edge values and occasional resets.
    for (int i = 0; i < 1500; i++) begin
      case ($urandom_range(0, 3))
        0:       s = $urandom_range(0, 4095);
        1:       s = 2048 + int'($urandom_range(1, 9)) * THRESH_STEP - int'($urandom_range(0, 1));
        2:       s = 2047 - int'($urandom_range(1, 9)) * THRESH_STEP + int'($urandom_range(0, 1));
        default: s = 2048 + int'($urandom_range(0, 300)) - 150;
      endcase
      drive(s);
      if ($urandom_range(0, 99) < 30) idle($urandom_range(1, 3));
      if ($urandom_range(0, 99) < 2) do_reset();
    end
    idle(3);

    // Drain: every expected pulse must have appeared within a bounded time.
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) idle(1);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing pulses: %0d outstanding, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
